// File: rtl/ripple_count_sampler.sv
// ripple_count_sampler
//   Consumes the output of an asynchronous ripple up-counter. The raw count is
//   synchronised into the clk domain and passed through a stability filter so
//   that ripple glitches are never taken as real steps. Each accepted step is
//   added (modulo 2^IN_W) to a wide running total, which is offered on a
//   valid/ready output. Steps arriving while the consumer stalls are coalesced
//   into the total and delivered on the next handshake.
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous active-low reset
//   q_async    in   IN_W   ripple counter output, asynchronous to clk
//   clr        in   1      synchronous clear of total, count, handshake and err
//   out_ready  in   1      consumer accepts count this cycle
//   out_valid  out  1      count holds a new, unconsumed value
//   count      out  EXT_W  extended running count
//   wrap_pulse out  1      one-cycle pulse when the total wraps to zero
//   err        out  1      sticky: an accepted step exceeded MAX_STEP
module ripple_count_sampler #(
    parameter int IN_W          = 2,
    parameter int EXT_W         = 8,
    parameter int STABLE_CYCLES = 2,
    parameter int MAX_STEP      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  q_async,
    input  logic             clr,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [EXT_W-1:0] count,
    output logic             wrap_pulse,
    output logic             err
);

    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    logic [IN_W-1:0]  sync1_r, sync2_r, stab_r;
    logic [2:0]       fill_r;
    logic [RUN_W-1:0] run_r, run_nxt_s;
    logic             stable_s;

    state_t           state_r, state_nxt_s;
    logic [IN_W-1:0]  baseline_r, baseline_nxt_s;
    logic [EXT_W-1:0] total_r, total_nxt_s;
    logic [EXT_W-1:0] count_nxt_s;
    logic             valid_nxt_s, wrap_nxt_s, err_nxt_s;
    logic             accept_s;
    logic [IN_W-1:0]  delta_s;
    logic [EXT_W:0]   sum_s;

    // Run-length of the filtered value. fill_r marks which pipeline stages hold
    // real samples, so the zeros left behind by reset are never taken as a
    // stable value and never become the INIT baseline.
    always_comb begin
        run_nxt_s = run_r;
        if (!fill_r[1]) begin
            run_nxt_s = {RUN_W{1'b0}};
        end else if (!fill_r[2] || (sync2_r != stab_r)) begin
            run_nxt_s = {{(RUN_W-1){1'b0}}, 1'b1};
        end else if (run_r != RUN_MAX) begin
            run_nxt_s = run_r + {{(RUN_W-1){1'b0}}, 1'b1};
        end else begin
            run_nxt_s = run_r;
        end
    end

    // Two-flop synchroniser, filter stage and run counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_r <= {IN_W{1'b0}};
            sync2_r <= {IN_W{1'b0}};
            stab_r  <= {IN_W{1'b0}};
            fill_r  <= 3'b000;
            run_r   <= {RUN_W{1'b0}};
        end else begin
            sync1_r <= q_async;
            sync2_r <= sync1_r;
            stab_r  <= sync2_r;
            fill_r  <= {fill_r[1:0], 1'b1};
            run_r   <= run_nxt_s;
        end
    end

    assign stable_s = (run_r == RUN_MAX);
    assign accept_s = (state_r == ST_TRACK) && stable_s && (stab_r != baseline_r);
    // Modular difference: a counter wrap such as 3 -> 0 is a forward step of 1.
    assign delta_s  = stab_r - baseline_r;
    assign sum_s    = {1'b0, total_r} + (EXT_W+1)'(delta_s);

    // Next-state, total accumulation and output handshake.
    always_comb begin
        state_nxt_s    = state_r;
        baseline_nxt_s = baseline_r;
        total_nxt_s    = total_r;
        count_nxt_s    = count;
        valid_nxt_s    = out_valid;
        wrap_nxt_s     = 1'b0;
        err_nxt_s      = err;
        if (clr) begin
            // Any accept in this cycle is dropped along with the old total.
            total_nxt_s = {EXT_W{1'b0}};
            count_nxt_s = {EXT_W{1'b0}};
            valid_nxt_s = 1'b0;
            err_nxt_s   = 1'b0;
            if (stable_s) begin
                baseline_nxt_s = stab_r;
                state_nxt_s    = ST_TRACK;
            end else begin
                state_nxt_s    = ST_INIT;
            end
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (stable_s) begin
                        baseline_nxt_s = stab_r;
                        state_nxt_s    = ST_TRACK;
                    end else begin
                        state_nxt_s    = ST_INIT;
                    end
                end
                ST_TRACK: begin
                    if (accept_s) begin
                        baseline_nxt_s = stab_r;
                        total_nxt_s    = sum_s[EXT_W-1:0];
                        wrap_nxt_s     = sum_s[EXT_W];
                        err_nxt_s      = err || (int'(delta_s) > MAX_STEP);
                    end else begin
                        total_nxt_s    = total_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_INIT;
                end
            endcase

            // total_nxt_s already includes a same-cycle accept, so a handshake
            // coinciding with an accept delivers the updated total.
            if (!out_valid) begin
                if (accept_s) begin
                    count_nxt_s = total_nxt_s;
                    valid_nxt_s = 1'b1;
                end else begin
                    valid_nxt_s = 1'b0;
                end
            end else if (out_ready) begin
                if (total_nxt_s != count) begin
                    count_nxt_s = total_nxt_s;
                    valid_nxt_s = 1'b1;
                end else begin
                    valid_nxt_s = 1'b0;
                end
            end else begin
                count_nxt_s = count;
                valid_nxt_s = 1'b1;
            end
        end
    end

    // State, total and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_INIT;
            baseline_r <= {IN_W{1'b0}};
            total_r    <= {EXT_W{1'b0}};
            count      <= {EXT_W{1'b0}};
            out_valid  <= 1'b0;
            wrap_pulse <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            baseline_r <= baseline_nxt_s;
            total_r    <= total_nxt_s;
            count      <= count_nxt_s;
            out_valid  <= valid_nxt_s;
            wrap_pulse <= wrap_nxt_s;
            err        <= err_nxt_s;
        end
    end

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Testbench for ripple_count_sampler: table of held input patterns with
// expected outputs, plus hand-written sequences for latency, total wrap,
// glitch rejection and reset during a pending handshake.
module tb_ripple_count_sampler;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] q_async;
    logic       clr;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] count;
    logic       wrap_pulse;
    logic       err;

    int checks   = 0;
    int failures = 0;

    ripple_count_sampler #(
        .IN_W(2), .EXT_W(8), .STABLE_CYCLES(2), .MAX_STEP(1)
    ) dut (
        .clk(clk), .rst(rst), .q_async(q_async), .clr(clr),
        .out_ready(out_ready), .out_valid(out_valid), .count(count),
        .wrap_pulse(wrap_pulse), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] q;
        logic       rdy;
        logic       clr;
        int         cyc;
        logic [7:0] cnt;
        logic       vld;
        logic       err;
    } row_t;

    row_t rows [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            q_async   = rows[i].q;
            out_ready = rows[i].rdy;
            clr       = rows[i].clr;
            repeat (rows[i].cyc) tick();
            clr = 1'b0;
            check($sformatf("row%0d_count", i), 32'(count), 32'(rows[i].cnt));
            check($sformatf("row%0d_valid", i), 32'(out_valid), 32'(rows[i].vld));
            check($sformatf("row%0d_err", i), 32'(err), 32'(rows[i].err));
        end
    endtask

    initial begin
        int seen_v;
        int seen_e;
        int seen_w;

        // q, rdy, clr, cycles, expected count, valid, err
        rows[0]  = '{2'd0, 1'b1, 1'b0, 10, 8'd1, 1'b0, 1'b0}; // 3->0 is a +1 step
        rows[1]  = '{2'd0, 1'b1, 1'b1, 1,  8'd0, 1'b0, 1'b0}; // clr, baseline 0
        rows[2]  = '{2'd1, 1'b1, 1'b1, 1,  8'd0, 1'b0, 1'b0}; // clr, baseline 1
        rows[3]  = '{2'd2, 1'b0, 1'b0, 10, 8'd1, 1'b1, 1'b0}; // stalled consumer
        rows[4]  = '{2'd3, 1'b0, 1'b0, 10, 8'd1, 1'b1, 1'b0}; // coalesced
        rows[5]  = '{2'd0, 1'b0, 1'b0, 10, 8'd1, 1'b1, 1'b0}; // coalesced
        rows[6]  = '{2'd0, 1'b1, 1'b0, 1,  8'd3, 1'b1, 1'b0}; // first ready
        rows[7]  = '{2'd0, 1'b1, 1'b0, 1,  8'd3, 1'b0, 1'b0}; // second ready
        rows[8]  = '{2'd0, 1'b1, 1'b1, 1,  8'd0, 1'b0, 1'b0}; // clr, baseline 0
        rows[9]  = '{2'd2, 1'b1, 1'b0, 10, 8'd2, 1'b0, 1'b1}; // step of 2
        rows[10] = '{2'd2, 1'b1, 1'b0, 10, 8'd2, 1'b0, 1'b1}; // err sticky
        rows[11] = '{2'd2, 1'b1, 1'b1, 1,  8'd0, 1'b0, 1'b0}; // clr clears err

        // Reset with counter at 3
        rst = 1'b0; q_async = 2'd3; clr = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wrap", 32'(wrap_pulse), 32'd0);
        rst = 1'b1;
        seen_v = 0; seen_e = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid) seen_v++;
            if (err) seen_e++;
        end
        check("init_no_valid", 32'(seen_v), 32'd0);
        check("init_no_err", 32'(seen_e), 32'd0);

        run_rows(0, 1);

        // Latency: 0->1 seen exactly 5 edges later, consumed on the 6th
        q_async = 2'd1;
        seen_v = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (out_valid) seen_v++;
        end
        check("lat_early_valid", 32'(seen_v), 32'd0);
        tick();
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_count", 32'(count), 32'd1);
        tick();
        check("lat_consumed", 32'(out_valid), 32'd0);

        run_rows(2, 8);

        // Total wrap: 255 single steps, then 3->0 carries out of 8 bits
        for (int i = 1; i <= 255; i++) begin
            q_async = i[1:0];
            repeat (7) tick();
        end
        check("pre_wrap_count", 32'(count), 32'd255);
        check("pre_wrap_err", 32'(err), 32'd0);
        q_async = 2'd0;
        seen_w = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (wrap_pulse) seen_w++;
        end
        check("wrap_early", 32'(seen_w), 32'd0);
        tick();
        check("wrap_pulse", 32'(wrap_pulse), 32'd1);
        check("wrap_count", 32'(count), 32'd0);
        check("wrap_valid", 32'(out_valid), 32'd1);
        seen_w = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (wrap_pulse) seen_w++;
        end
        check("wrap_one_cycle", 32'(seen_w), 32'd0);
        check("wrap_err", 32'(err), 32'd0);

        run_rows(9, 11);

        // One-cycle glitch 2->3->2 must never be accepted
        q_async = 2'd3;
        tick();
        q_async = 2'd2;
        seen_v = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (out_valid) seen_v++;
        end
        check("glitch_no_valid", 32'(seen_v), 32'd0);
        check("glitch_count", 32'(count), 32'd0);

        // Pending value, glitch in flight, then reset
        out_ready = 1'b0;
        q_async = 2'd3;
        repeat (8) tick();
        check("pend_valid", 32'(out_valid), 32'd1);
        check("pend_count", 32'(count), 32'd1);
        q_async = 2'd0;
        tick();
        q_async = 2'd3;
        tick();
        rst = 1'b0;
        tick();
        check("rst2_valid", 32'(out_valid), 32'd0);
        check("rst2_count", 32'(count), 32'd0);
        check("rst2_err", 32'(err), 32'd0);
        check("rst2_wrap", 32'(wrap_pulse), 32'd0);
        rst = 1'b1;
        out_ready = 1'b1;
        seen_v = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid) seen_v++;
        end
        check("post_rst_no_valid", 32'(seen_v), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
